mem_port_arbiter: RTL and testbench

- Shares one single-port unified memory between instruction fetch and data load/store.
- Sequences every memory access and returns read data to the winning requester.
- Generates the load_instr pulse and instruction word for the instruction register.
- Sits between the PC/fetch logic, the load/store datapath and the memory macro; enforces data-over-fetch priority with a bounded starvation limit, atomic locking, fetch flush and an access timeout.

---
 rtl/mem_port_arbiter_pkg.sv | 19 +
 rtl/mem_port_arbiter_if.sv | 42 ++++
 rtl/arb_timeout_ctr.sv | 29 ++
 rtl/mem_port_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states, grant encoding
// and the data-over-fetch arbitration rule.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {StIdle, StFetch, StData, StResp} state_e;

   typedef enum logic [1:0] {GntNone, GntFetch, GntData} grant_e;

   localparam logic [3:0] AllBytes = 4'hF;

   // Data wins unless fetch is pending and data has already used its streak (and holds no lock).
   function automatic grant_e arbitrate(input logic d_req, input logic if_req,
                                        input logic streak_max, input logic lock_held);
      if (d_req && (!if_req || !streak_max || lock_held)) return GntData;
      if (if_req) return GntFetch;
      return GntNone;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the port arbiter; master is the arbiter view.
interface mem_port_arbiter_if #(
   parameter int unsigned BITS      = 32,
   parameter int unsigned ADDR_BITS = 16
) ();
   logic                 if_req;
   logic [ADDR_BITS-1:0] if_addr;
   logic                 flush;
   logic                 d_req;
   logic                 d_rw_;
   logic [ADDR_BITS-1:0] d_addr;
   logic [BITS-1:0]      d_wdata;
   logic [3:0]           d_byte_en;
   logic                 d_lock;
   logic                 if_done;
   logic                 load_instr;
   logic [BITS-1:0]      instr_data;
   logic                 d_done;
   logic [BITS-1:0]      d_rdata;
   logic                 bus_err;
   logic                 m_req;
   logic                 m_rw_;
   logic [ADDR_BITS-1:0] m_addr;
   logic [BITS-1:0]      m_wdata;
   logic [3:0]           m_byte_en;
   logic                 m_ack;
   logic [BITS-1:0]      m_rdata;

   modport master (
      input  if_req, if_addr, flush, d_req, d_rw_, d_addr, d_wdata, d_byte_en, d_lock,
             m_ack, m_rdata,
      output if_done, load_instr, instr_data, d_done, d_rdata, bus_err,
             m_req, m_rw_, m_addr, m_wdata, m_byte_en
   );

   modport slave (
      output if_req, if_addr, flush, d_req, d_rw_, d_addr, d_wdata, d_byte_en, d_lock,
             m_ack, m_rdata,
      input  if_done, load_instr, instr_data, d_done, d_rdata, bus_err,
             m_req, m_rw_, m_addr, m_wdata, m_byte_en
   );
endinterface

// File: rtl/arb_timeout_ctr.sv
// Loadable down-counter; expire_o is high while the count sits at zero.
module arb_timeout_ctr #(
   parameter int unsigned Width = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic [Width-1:0] load_val_i,
   input  logic             en_i,
   output logic             expire_o
);
   logic [Width-1:0] cnt_d, cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - Width'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   assign expire_o = (cnt_q == '0);
endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data load/store, with bounded
// data streaks, atomic lock, fetch flush and an ack timeout.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned BITS       = 32,
   parameter int unsigned ADDR_BITS  = 16,
   parameter int unsigned MAX_STREAK = 3,
   parameter int unsigned TIMEOUT    = 15
) (
   input logic                clk,
   input logic                rst_,
   mem_port_arbiter_if.master bus
);
   localparam int unsigned StreakW = $clog2(MAX_STREAK + 1);
   localparam int unsigned TmrW    = $clog2(TIMEOUT + 1);
   localparam logic [StreakW-1:0] StreakMax = StreakW'(MAX_STREAK);
   // Loaded at grant so the count hits zero in the TIMEOUT-th cycle of the access.
   localparam logic [TmrW-1:0]    TmrLoad   = TmrW'(TIMEOUT - 1);

   state_e               state_d, state_q;
   logic [StreakW-1:0]   streak_d, streak_q;
   logic                 lock_d, lock_q;
   logic                 flushed_d, flushed_q;
   logic                 err_d, err_q;
   logic                 is_data_d, is_data_q;
   logic [BITS-1:0]      data_d, data_q;
   logic                 m_req_d, m_req_q;
   logic                 m_rw_d, m_rw_q;
   logic [ADDR_BITS-1:0] m_addr_d, m_addr_q;
   logic [BITS-1:0]      m_wdata_d, m_wdata_q;
   logic [3:0]           m_be_d, m_be_q;
   grant_e               gnt;
   logic                 tmr_load, tmr_en, tmr_expire;

   arb_timeout_ctr #(
      .Width (TmrW)
   ) u_tmr (
      .clk_i      (clk),
      .rst_ni     (rst_),
      .load_i     (tmr_load),
      .load_val_i (TmrLoad),
      .en_i       (tmr_en),
      .expire_o   (tmr_expire)
   );

   always_comb begin
      state_d   = state_q;
      streak_d  = streak_q;
      lock_d    = lock_q;
      flushed_d = flushed_q;
      err_d     = err_q;
      is_data_d = is_data_q;
      data_d    = data_q;
      m_req_d   = m_req_q;
      m_rw_d    = m_rw_q;
      m_addr_d  = m_addr_q;
      m_wdata_d = m_wdata_q;
      m_be_d    = m_be_q;
      gnt       = GntNone;
      tmr_load  = 1'b0;
      tmr_en    = 1'b0;
      unique case (state_q)
         StIdle: begin
            gnt = arbitrate(bus.d_req, bus.if_req, streak_q == StreakMax, lock_q);
            if (gnt != GntNone) begin
               tmr_load = 1'b1;
               m_req_d  = 1'b1;
               err_d    = 1'b0;
            end
            if (gnt == GntData) begin
               state_d   = StData;
               is_data_d = 1'b1;
               m_rw_d    = bus.d_rw_;
               m_addr_d  = bus.d_addr;
               m_wdata_d = bus.d_wdata;
               m_be_d    = bus.d_byte_en;
               lock_d    = bus.d_lock;
               if (!bus.if_req)                streak_d = '0;
               else if (streak_q != StreakMax) streak_d = streak_q + StreakW'(1);
            end else if (gnt == GntFetch) begin
               state_d   = StFetch;
               is_data_d = 1'b0;
               m_rw_d    = 1'b1;
               m_addr_d  = bus.if_addr;
               m_wdata_d = '0;
               m_be_d    = AllBytes;
               lock_d    = 1'b0;
               streak_d  = '0;
            end
         end
         StFetch, StData: begin
            if ((state_q == StFetch) && bus.flush) flushed_d = 1'b1;
            if (bus.m_ack) begin
               data_d  = bus.m_rdata;
               m_req_d = 1'b0;
               state_d = StResp;
            end else if (tmr_expire) begin
               data_d  = '0;
               err_d   = 1'b1;
               m_req_d = 1'b0;
               state_d = StResp;
            end else begin
               tmr_en = 1'b1;
            end
         end
         StResp: begin
            state_d   = StIdle;
            flushed_d = 1'b0;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state_q   <= StIdle;
         streak_q  <= '0;
         lock_q    <= 1'b0;
         flushed_q <= 1'b0;
         err_q     <= 1'b0;
         is_data_q <= 1'b0;
         data_q    <= '0;
         m_req_q   <= 1'b0;
         m_rw_q    <= 1'b1;
         m_addr_q  <= '0;
         m_wdata_q <= '0;
         m_be_q    <= AllBytes;
      end else begin
         state_q   <= state_d;
         streak_q  <= streak_d;
         lock_q    <= lock_d;
         flushed_q <= flushed_d;
         err_q     <= err_d;
         is_data_q <= is_data_d;
         data_q    <= data_d;
         m_req_q   <= m_req_d;
         m_rw_q    <= m_rw_d;
         m_addr_q  <= m_addr_d;
         m_wdata_q <= m_wdata_d;
         m_be_q    <= m_be_d;
      end
   end

   logic resp;
   assign resp           = (state_q == StResp);
   assign bus.if_done    = resp && !is_data_q;
   assign bus.d_done     = resp && is_data_q;
   assign bus.bus_err    = resp && err_q;
   // A flush landing in the done cycle itself still suppresses the load.
   assign bus.load_instr = bus.if_done && !flushed_q && !bus.flush && !err_q;
   assign bus.instr_data = bus.if_done ? data_q : '0;
   assign bus.d_rdata    = bus.d_done ? data_q : '0;
   assign bus.m_req      = m_req_q;
   assign bus.m_rw_      = m_rw_q;
   assign bus.m_addr     = m_addr_q;
   assign bus.m_wdata    = m_wdata_q;
   assign bus.m_byte_en  = m_be_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a transaction-level reference model.
module tb_mem_port_arbiter;
   localparam int unsigned MaxStreak = 3;
   localparam int unsigned Timeout   = 15;

   logic clk = 1'b0;
   logic rst_;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.BITS(32), .ADDR_BITS(16)) bus ();

   mem_port_arbiter #(
      .BITS       (32),
      .ADDR_BITS  (16),
      .MAX_STREAK (MaxStreak),
      .TIMEOUT    (Timeout)
   ) dut (
      .clk  (clk),
      .rst_ (rst_),
      .bus  (bus)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_str(input string name, input string act, input string exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got '%s', want '%s'", name, act, exp);
      end
   endtask

   function automatic string q2s(input byte q[$]);
      string s = "";
      foreach (q[i]) s = {s, $sformatf("%c", q[i])};
      return s;
   endfunction

   // Memory: acks after mem_lat extra cycles of m_req; mem_off withholds the ack.
   int          mem_lat = 1;
   bit          mem_off = 1'b0;
   logic        stray_ack = 1'b0;
   int          mcnt;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   assign bus.m_ack   = mem_ack | stray_ack;
   assign bus.m_rdata = mem_rdata;

   function automatic logic [31:0] rd_fn(input logic [15:0] a);
      return (a == 16'h0010) ? 32'h2008_0005 : {~a, a};
   endfunction

   always @(negedge clk or negedge rst_) begin
      if (!rst_) begin
         mem_ack <= 1'b0; mcnt <= 0; mem_rdata <= '0;
      end else if (bus.m_req && !mem_ack) begin
         if (!mem_off && mcnt >= mem_lat) begin
            mem_ack   <= 1'b1;
            mem_rdata <= rd_fn(bus.m_addr);
         end else begin
            mcnt <= mcnt + 1;
         end
      end else begin
         mem_ack <= 1'b0; mcnt <= 0; mem_rdata <= '0;
      end
   end

   // Reference model: one access at a time, age counts cycles since grant.
   logic        mbusy, mresp, mwho, merr, mflag, mlock, mrw;
   int unsigned mage, mstreak;
   logic [31:0] mdata, mwdata;
   logic [15:0] maddr;
   logic [3:0]  mbe;
   byte         mgnt[$];
   byte         dgnt[$];
   logic        m_take_d;
   assign m_take_d = bus.d_req && (!bus.if_req || mstreak < MaxStreak || mlock);

   always @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         mbusy <= 0; mresp <= 0; mwho <= 0; merr <= 0; mflag <= 0; mlock <= 0;
         mage <= 0; mstreak <= 0; mdata <= 0; maddr <= 0; mwdata <= 0;
         mbe <= 4'hF; mrw <= 1'b1;
      end else if (mresp) begin
         mresp <= 1'b0; mflag <= 1'b0;
      end else if (mbusy) begin
         if (!mwho && bus.flush) mflag <= 1'b1;
         if (bus.m_ack) begin
            mbusy <= 0; mresp <= 1; mdata <= bus.m_rdata; merr <= 0;
         end else if (mage == Timeout) begin
            mbusy <= 0; mresp <= 1; mdata <= 0; merr <= 1;
         end else begin
            mage <= mage + 1;
         end
      end else if (m_take_d) begin
         mbusy <= 1; mwho <= 1; mage <= 1;
         maddr <= bus.d_addr; mwdata <= bus.d_wdata; mbe <= bus.d_byte_en; mrw <= bus.d_rw_;
         mstreak <= !bus.if_req ? 0 : (mstreak < MaxStreak ? mstreak + 1 : MaxStreak);
         mlock <= bus.d_lock;
         mgnt.push_back("D");
      end else if (bus.if_req) begin
         mbusy <= 1; mwho <= 0; mage <= 1;
         maddr <= bus.if_addr; mwdata <= 0; mbe <= 4'hF; mrw <= 1'b1;
         mstreak <= 0; mlock <= 0;
         mgnt.push_back("F");
      end
   end

   // Every-cycle comparison against the model, sampled between edges.
   logic prev_mreq = 1'b0;
   always @(negedge clk) begin
      logic e_ifd, e_dd;
      #3;
      e_ifd = mresp && !mwho;
      e_dd  = mresp && mwho;
      chk("m_req",      bus.m_req,      mbusy);
      chk("m_rw_",      bus.m_rw_,      mrw);
      chk("m_addr",     bus.m_addr,     maddr);
      chk("m_wdata",    bus.m_wdata,    mwdata);
      chk("m_byte_en",  bus.m_byte_en,  mbe);
      chk("if_done",    bus.if_done,    e_ifd);
      chk("d_done",     bus.d_done,     e_dd);
      chk("bus_err",    bus.bus_err,    mresp && merr);
      chk("load_instr", bus.load_instr, e_ifd && !mflag && !bus.flush && !merr);
      chk("instr_data", bus.instr_data, e_ifd ? mdata : 32'h0);
      chk("d_rdata",    bus.d_rdata,    e_dd ? mdata : 32'h0);
      if (rst_ && bus.m_req && !prev_mreq) dgnt.push_back((bus.m_addr == bus.d_addr) ? "D" : "F");
      prev_mreq <= bus.m_req;
   end

   task automatic do_reset();
      rst_ = 1'b0;
      bus.if_req = 0; bus.if_addr = '0; bus.flush = 0; bus.d_req = 0; bus.d_rw_ = 1;
      bus.d_addr = '0; bus.d_wdata = '0; bus.d_byte_en = 4'hF; bus.d_lock = 0;
      mem_off = 0; mem_lat = 1; stray_ack = 0;
      repeat (2) @(negedge clk);
      rst_ = 1'b1;
      dgnt.delete(); mgnt.delete();
   endtask

   initial begin
      int cnt;
      int n_dd;
      bit seen;
      rst_ = 1'b1;
      #1;
      do_reset();
      chk("rst_m_rw_", bus.m_rw_, 1'b1);
      chk("rst_m_byte_en", bus.m_byte_en, 4'hF);
      chk("rst_m_req", bus.m_req, 1'b0);

      // Fetch only: m_req in cycle 1, ack in cycle 2, done/load in cycle 3.
      bus.if_req = 1; bus.if_addr = 16'h0010;
      @(negedge clk); #4;
      chk("fetch_c1_m_req", bus.m_req, 1'b1);
      chk("fetch_c1_m_addr", bus.m_addr, 16'h0010);
      @(negedge clk); #4;
      chk("fetch_c2_m_ack", bus.m_ack, 1'b1);
      @(negedge clk); #4;
      chk("fetch_c3_if_done", bus.if_done, 1'b1);
      chk("fetch_c3_load", bus.load_instr, 1'b1);
      chk("fetch_c3_instr", bus.instr_data, 32'h2008_0005);
      bus.if_req = 0;
      repeat (2) @(negedge clk);

      // Contention with zero-wait memory; data side is a partial write.
      do_reset();
      mem_lat = 0;
      bus.if_addr = 16'h0100; bus.d_addr = 16'h0200; bus.d_rw_ = 0;
      bus.d_wdata = 32'hCAFE_F00D; bus.d_byte_en = 4'h3;
      bus.if_req = 1; bus.d_req = 1;
      for (int i = 0; i < 200 && dgnt.size() < 8; i++) @(negedge clk);
      chk_str("contend_dut_order", q2s(dgnt), "DDDFDDDF");
      chk_str("contend_model_order", q2s(mgnt), "DDDFDDDF");

      // Lock on the third data grant keeps data priority once more.
      do_reset();
      bus.if_addr = 16'h0100; bus.d_addr = 16'h0200;
      bus.if_req = 1; bus.d_req = 1;
      n_dd = 0;
      for (int i = 0; i < 300 && dgnt.size() < 5; i++) begin
         @(negedge clk);
         if (bus.d_done) n_dd++;
         bus.d_lock = (n_dd == 2);
      end
      chk_str("lock_dut_order", q2s(dgnt), "DDDDF");
      chk_str("lock_model_order", q2s(mgnt), "DDDDF");

      // Flush in the ack cycle of a fetch.
      do_reset();
      bus.if_req = 1; bus.if_addr = 16'h0044;
      @(negedge clk);
      @(negedge clk);
      bus.flush = 1; #4;
      chk("flush_ack_cycle", bus.m_ack, 1'b1);
      @(negedge clk);
      bus.flush = 0; #4;
      chk("flush_if_done", bus.if_done, 1'b1);
      chk("flush_load_instr", bus.load_instr, 1'b0);
      bus.if_req = 0;
      repeat (2) @(negedge clk);

      // Timeout: m_req held for exactly Timeout cycles, then an error response.
      do_reset();
      mem_off = 1;
      bus.d_req = 1; bus.d_rw_ = 1; bus.d_addr = 16'h0300;
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk); #4;
         if (bus.m_req) cnt++;
         else break;
      end
      chk("tmo_mreq_cycles", cnt, 15);
      chk("tmo_d_done", bus.d_done, 1'b1);
      chk("tmo_bus_err", bus.bus_err, 1'b1);
      chk("tmo_d_rdata", bus.d_rdata, 32'h0);
      bus.d_req = 0; mem_off = 0;
      repeat (2) @(negedge clk);

      // Stray acks in idle must not start anything.
      stray_ack = 1;
      repeat (3) @(negedge clk);
      #4;
      chk("stray_no_req", bus.m_req, 1'b0);
      stray_ack = 0;
      @(negedge clk);

      // Reset in the middle of a data access.
      do_reset();
      mem_off = 1;
      bus.d_req = 1; bus.d_rw_ = 1; bus.d_addr = 16'h0400;
      repeat (3) @(negedge clk);
      #1 rst_ = 1'b0;
      #1 chk("rst_mid_m_req", bus.m_req, 1'b0);
      seen = 0;
      repeat (3) begin
         @(negedge clk);
         if (bus.d_done) seen = 1;
      end
      chk("rst_mid_no_done", seen, 1'b0);
      rst_ = 1'b1; mem_off = 0;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.d_done) begin
            seen = 1;
            chk("rst_after_rdata", bus.d_rdata, {~16'h0400, 16'h0400});
            break;
         end
      end
      chk("rst_after_served", seen, 1'b1);
      bus.d_req = 0;
      repeat (3) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (limit 200000)");
      $fatal(1, "watchdog");
   end
endmodule
